fifo_wptr_full: RTL and testbench

//  Write-side pointer and full-flag stage of the dual-clock FIFO. Keeps the write

---
 rtl/fifo_cdc_pkg.sv | 22 ++
 rtl/fifo_wptr_full_if.sv | 26 ++
 rtl/fifo_gray_cnt.sv | 32 +++
 rtl/fifo_wptr_full.sv | 71 +++++++
 tb/tb_fifo_wptr_full.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/fifo_cdc_pkg.sv
// Shared definitions for the dual-clock FIFO pointer stages.
// Pointers are converted between binary and Gray code here.
package fifo_cdc_pkg;

    localparam int ADDR_W_DEF = 4;
    localparam int FN_W       = 32;

    function automatic logic [FN_W-1:0] bin2gray(input logic [FN_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [FN_W-1:0] gray2bin(input logic [FN_W-1:0] g);
        logic [FN_W-1:0] b;
        b          = '0;
        b[FN_W-1]  = g[FN_W-1];
        for (int i = FN_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/fifo_wptr_full_if.sv
// Write-side bus of the FIFO: producer handshake, synchronized read pointer,
// RAM write port and write-domain status.
interface fifo_wptr_full_if import fifo_cdc_pkg::*; #(
    parameter int ADDR_W = ADDR_W_DEF
);
    logic              winc;
    logic [ADDR_W:0]   rq2_rptr;
    logic              ovf_clr;
    logic              wen;
    logic [ADDR_W-1:0] waddr;
    logic [ADDR_W:0]   wptr;
    logic              wfull;
    logic              wafull;
    logic [ADDR_W:0]   wcount;
    logic              wovf;

    modport master (
        output winc, rq2_rptr, ovf_clr,
        input  wen, waddr, wptr, wfull, wafull, wcount, wovf
    );

    modport slave (
        input  winc, rq2_rptr, ovf_clr,
        output wen, waddr, wptr, wfull, wafull, wcount, wovf
    );
endinterface

// File: rtl/fifo_gray_cnt.sv
// Registered binary + Gray pointer counter with increment enable.
// Shared by the write-full and read-empty pointer stages.
module fifo_gray_cnt import fifo_cdc_pkg::*; #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] bin,
    output logic [W-1:0] gray,
    output logic [W-1:0] bin_next,
    output logic [W-1:0] gray_next
);

    // NOTE: every output of always_comb is assigned on every pass, so no latch is inferred.
    always_comb begin
        bin_next  = bin + W'(inc);
        gray_next = W'(bin2gray(FN_W'(bin_next)));
    end

    // NOTE: non-blocking assignments so each flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bin  <= '0;
            gray <= '0;
        end else begin
            bin  <= bin_next;
            gray <= gray_next;
        end
    end

endmodule

// File: rtl/fifo_wptr_full.sv
// Write-domain pointer and full/almost-full/count/overflow status of the
// dual-clock FIFO, computed against the synchronized Gray read pointer.
module fifo_wptr_full import fifo_cdc_pkg::*; #(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int AFULL_TH = 2
) (
    input  logic             clk,
    input  logic             rst,
    fifo_wptr_full_if.slave  bus
);

    localparam int PTR_W = ADDR_W + 1;
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [PTR_W-1:0] AFULL_LVL = PTR_W'(DEPTH - AFULL_TH);

    logic             wen;
    logic [PTR_W-1:0] wbin, wgray, wbin_n, wgray_n;
    logic [PTR_W-1:0] rbin_s, full_cmp, wcount_n;
    logic [PTR_W-1:0] wcount_q;
    logic             wfull_q, wafull_q, wovf_q;
    logic             unused_wbin_msb;

    assign wen = bus.winc & ~wfull_q;

    fifo_gray_cnt #(.W(PTR_W)) u_wcnt (
        .clk       (clk),
        .rst       (rst),
        .inc       (wen),
        .bin       (wbin),
        .gray      (wgray),
        .bin_next  (wbin_n),
        .gray_next (wgray_n)
    );

    // Full when the next write pointer has lapped the read pointer once:
    // in Gray code that is the top two bits inverted, the rest equal.
    always_comb begin
        full_cmp = {~bus.rq2_rptr[ADDR_W:ADDR_W-1], bus.rq2_rptr[ADDR_W-2:0]};
        rbin_s   = PTR_W'(gray2bin(FN_W'(bus.rq2_rptr)));
        wcount_n = wbin_n - rbin_s;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wfull_q  <= 1'b0;
            wafull_q <= 1'b0;
            wcount_q <= '0;
            wovf_q   <= 1'b0;
        end else begin
            wfull_q  <= (wgray_n == full_cmp);
            wafull_q <= (wcount_n >= AFULL_LVL);
            wcount_q <= wcount_n;
            if (bus.winc && wfull_q) begin
                wovf_q <= 1'b1;
            end else if (bus.ovf_clr) begin
                wovf_q <= 1'b0;
            end
        end
    end

    assign unused_wbin_msb = wbin[ADDR_W];

    assign bus.wen    = wen;
    assign bus.waddr  = wbin[ADDR_W-1:0];
    assign bus.wptr   = wgray;
    assign bus.wfull  = wfull_q;
    assign bus.wafull = wafull_q;
    assign bus.wcount = wcount_q;
    assign bus.wovf   = wovf_q;

endmodule

// File: tb/tb_fifo_wptr_full.sv
// Self-checking bench for fifo_wptr_full: directed scenarios plus random
// traffic against a fill-level model kept in plain write/read totals.
module tb_fifo_wptr_full;

    localparam int AW    = 4;
    localparam int DEPTH = 16;
    localparam int ATH   = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;

    fifo_wptr_full_if #(.ADDR_W(AW)) bus ();

    fifo_wptr_full #(.ADDR_W(AW), .AFULL_TH(ATH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model state: totals of accepted writes and registered status.
    int unsigned m_wr    = 0;
    int unsigned m_count = 0;
    bit          m_full  = 1'b0;
    bit          m_afull = 1'b0;
    bit          m_ovf   = 1'b0;

    function automatic logic [4:0] to_gray(input int unsigned n);
        logic [4:0] b;
        b = 5'(n % 32);
        return b ^ (b >> 1);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        check("waddr",  32'(bus.waddr),  m_wr % DEPTH);
        check("wptr",   32'(bus.wptr),   32'(to_gray(m_wr)));
        check("wfull",  32'(bus.wfull),  32'(m_full));
        check("wafull", 32'(bus.wafull), 32'(m_afull));
        check("wcount", 32'(bus.wcount), m_count);
        check("wovf",   32'(bus.wovf),   32'(m_ovf));
    endtask

    function automatic void model_reset();
        m_wr    = 0;
        m_count = 0;
        m_full  = 1'b0;
        m_afull = 1'b0;
        m_ovf   = 1'b0;
    endfunction

    // Called at a negedge: drive, check wen, clock once, then check registers.
    task automatic drive(input bit w, input int unsigned rd, input bit clr);
        bit          acc;
        int unsigned fill;
        bus.winc     = w;
        bus.rq2_rptr = to_gray(rd);
        bus.ovf_clr  = clr;
        #1;
        acc = w && !m_full;
        check("wen", 32'(bus.wen), 32'(acc));
        @(posedge clk);
        m_ovf   = (w && m_full) ? 1'b1 : (clr ? 1'b0 : m_ovf);
        m_wr    = m_wr + (acc ? 1 : 0);
        fill    = m_wr - rd;
        m_count = fill;
        m_full  = (fill == DEPTH);
        m_afull = (fill >= DEPTH - ATH);
        @(negedge clk);
        compare_all();
    endtask

    task automatic do_reset();
        bus.winc     = 1'b0;
        bus.rq2_rptr = '0;
        bus.ovf_clr  = 1'b0;
        rst          = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        logic [4:0]  prev;
        int unsigned rd_tot;
        int          wprob;
        int          rprob;

        do_reset();
        compare_all();

        // Asynchronous reset in the middle of a write burst.
        for (int i = 0; i < 3; i++) drive(1'b1, 0, 1'b0);
        #3;
        rst = 1'b0;
        #1;
        check("rst_wptr",   32'(bus.wptr),   32'(5'b00000));
        check("rst_waddr",  32'(bus.waddr),  0);
        check("rst_wfull",  32'(bus.wfull),  0);
        check("rst_wafull", 32'(bus.wafull), 0);
        check("rst_wcount", 32'(bus.wcount), 0);
        check("rst_wovf",   32'(bus.wovf),   0);
        bus.winc = 1'b0;
        model_reset();
        @(negedge clk);
        rst = 1'b1;

        // Fill 16 entries with the read pointer parked at zero.
        for (int i = 0; i < DEPTH; i++) begin
            check("fill_waddr", 32'(bus.waddr), i);
            drive(1'b1, 0, 1'b0);
            check("fill_wafull", 32'(bus.wafull), (i >= 13) ? 1 : 0);
            check("fill_wfull",  32'(bus.wfull),  (i == 15) ? 1 : 0);
        end
        check("full_wptr",   32'(bus.wptr),   32'(5'b11000));
        check("full_wcount", 32'(bus.wcount), 16);

        // Writes while full: refused, overflow sticky, set beats clear.
        drive(1'b1, 0, 1'b0);
        check("ovf_wptr_hold", 32'(bus.wptr), 32'(5'b11000));
        check("ovf_set",       32'(bus.wovf), 1);
        drive(1'b1, 0, 1'b1);
        check("ovf_set_wins",  32'(bus.wovf), 1);
        drive(1'b0, 0, 1'b1);
        check("ovf_cleared",   32'(bus.wovf), 0);

        // Read pointer advances by one while the producer keeps pushing.
        drive(1'b1, 1, 1'b0);
        check("rel_wfull",  32'(bus.wfull),  0);
        check("rel_wcount", 32'(bus.wcount), 15);
        check("rel_wafull", 32'(bus.wafull), 1);
        check("rel_wptr",   32'(bus.wptr),   32'(5'b11000));
        drive(1'b1, 1, 1'b0);
        check("refill_wcount", 32'(bus.wcount), 16);
        check("refill_wfull",  32'(bus.wfull),  1);
        drive(1'b0, 1, 1'b1);

        // 40 writes with the read pointer trailing closely: one-bit Gray steps.
        do_reset();
        for (int i = 0; i < 40; i++) begin
            prev = bus.wptr;
            drive(1'b1, m_wr, 1'b0);
            check("gray_step", 32'($countones(prev ^ bus.wptr)), 1);
            check("track_wfull", 32'(bus.wfull), 0);
            if (m_wr == 32) begin
                check("wrap_prev", 32'(prev),     32'(5'b10000));
                check("wrap_wptr", 32'(bus.wptr), 32'(5'b00000));
            end
        end

        // Random traffic with phases of differing write/read pressure.
        do_reset();
        rd_tot = 0;
        for (int blk = 0; blk < 15; blk++) begin
            wprob = int'($urandom_range(20, 95));
            rprob = int'($urandom_range(5, 90));
            for (int c = 0; c < 200; c++) begin
                if (rd_tot < m_wr && int'($urandom_range(0, 99)) < rprob) rd_tot++;
                drive(int'($urandom_range(0, 99)) < wprob, rd_tot,
                      $urandom_range(0, 31) == 0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
